// File: rtl/counter_mod_n_if.sv
// Control and status bundle for counter_mod_n.
// The master drives count controls and the slave (the counter) returns count and status.
interface counter_mod_n_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             sclr;
    logic             load;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf_sticky;

    modport master (
        output en, up, sclr, load, ld_val,
        input  q, tc, wrap, ovf_sticky
    );

    modport slave (
        input  en, up, sclr, load, ld_val,
        output q, tc, wrap, ovf_sticky
    );
endinterface

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with load, sync clear, wrap/saturate and bound-event flags.
// Define COUNTER_MOD_STATUS_EN to build the sticky bound-event register behind ovf_sticky.
module counter_mod_n #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int unsigned     SATURATE = 0
) (
    input  logic              clk,
    input  logic              clr,
    counter_mod_n_if.slave    bus
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam bit               SAT   = (SATURATE != 0);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             at_bound;

    assign at_bound = bus.up ? (q_q == MAX_Q) : (q_q == '0);
    assign bus.tc   = bus.en & at_bound;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (bus.sclr) begin
            q_d = '0;
        end else if (bus.load) begin
            // Out-of-range loads clamp so q never leaves 0..MODULUS-1.
            q_d = (bus.ld_val > MAX_Q) ? MAX_Q : bus.ld_val;
        end else if (bus.en) begin
            wrap_d = at_bound;
            if (bus.up) begin
                q_d = at_bound ? (SAT ? q_q : '0) : q_q + ONE;
            end else begin
                q_d = at_bound ? (SAT ? q_q : MAX_Q) : q_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.wrap = wrap_q;

`ifdef COUNTER_MOD_STATUS_EN
    logic ovf_q;
    logic bound_evt;

    assign bound_evt = ~bus.sclr & ~bus.load & bus.tc;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ovf_q <= 1'b0;
        end else if (bus.sclr) begin
            ovf_q <= 1'b0;
        end else if (bound_evt) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf_sticky = ovf_q;
`else
    assign bus.ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_counter_mod_n.sv
// Scoreboard bench: wrapping and saturating counters share stimulus, plus a two-stage cascade.
module tb_counter_mod_n;

    localparam int M = 10;

    logic clk;
    logic clr;
    logic c_en;

    counter_mod_n_if #(.WIDTH(4)) b0 ();
    counter_mod_n_if #(.WIDTH(4)) b1 ();
    counter_mod_n_if #(.WIDTH(4)) bl ();
    counter_mod_n_if #(.WIDTH(4)) bh ();

    assign b1.en     = b0.en;
    assign b1.up     = b0.up;
    assign b1.sclr   = b0.sclr;
    assign b1.load   = b0.load;
    assign b1.ld_val = b0.ld_val;

    assign bl.en     = c_en;
    assign bl.up     = 1'b1;
    assign bl.sclr   = 1'b0;
    assign bl.load   = 1'b0;
    assign bl.ld_val = 4'd0;

    assign bh.en     = bl.tc;
    assign bh.up     = 1'b1;
    assign bh.sclr   = 1'b0;
    assign bh.load   = 1'b0;
    assign bh.ld_val = 4'd0;

    counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_wrap (
        .clk (clk), .clr (clr), .bus (b0)
    );
    counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
        .clk (clk), .clr (clr), .bus (b1)
    );
    counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_lo (
        .clk (clk), .clr (clr), .bus (bl)
    );
    counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_hi (
        .clk (clk), .clr (clr), .bus (bh)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int q[2];
        int w[2];
        int o[2];
        int t[2];
        int lo;
        int hi;
        int tlo;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: per-counter value, wrap pulse, sticky flag; cascade is a 0..99 tally.
    int mq[2];
    int mw[2];
    int mo[2];
    int n;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ovf_exp(input int o);
`ifdef COUNTER_MOD_STATUS_EN
        return o;
`else
        return 0 * o;
`endif
    endfunction

    task automatic drive(input bit en, input bit up, input bit sclr, input bit load,
                         input int ld);
        b0.en     = en;
        b0.up     = up;
        b0.sclr   = sclr;
        b0.load   = load;
        b0.ld_val = 4'(ld);
    endtask

    // Record what should be visible now, advance the model across the next edge, then step.
    task automatic step();
        exp_t e;
        bit   hit;
        int   ld;
        if (!clr) begin
            for (int k = 0; k < 2; k++) begin
                mq[k] = 0;
                mw[k] = 0;
                mo[k] = 0;
            end
            n = 0;
        end
        for (int k = 0; k < 2; k++) begin
            e.q[k] = mq[k];
            e.w[k] = mw[k];
            e.o[k] = ovf_exp(mo[k]);
            e.t[k] = (b0.en && (b0.up ? mq[k] == M - 1 : mq[k] == 0)) ? 1 : 0;
        end
        e.lo  = n % 10;
        e.hi  = (n / 10) % 10;
        e.tlo = (c_en && (n % 10 == 9)) ? 1 : 0;
        sb.push_back(e);

        if (clr) begin
            for (int k = 0; k < 2; k++) begin
                if (b0.sclr) begin
                    mq[k] = 0;
                    mw[k] = 0;
                    mo[k] = 0;
                end else if (b0.load) begin
                    ld    = int'(b0.ld_val);
                    mq[k] = (ld > M - 1) ? M - 1 : ld;
                    mw[k] = 0;
                end else if (b0.en) begin
                    hit = b0.up ? (mq[k] == M - 1) : (mq[k] == 0);
                    if (k == 0) mq[k] = b0.up ? (mq[k] + 1) % M : (mq[k] + M - 1) % M;
                    else if (b0.up) mq[k] = (mq[k] + 1 > M - 1) ? M - 1 : mq[k] + 1;
                    else mq[k] = (mq[k] - 1 < 0) ? 0 : mq[k] - 1;
                    mw[k] = hit ? 1 : 0;
                    if (hit) mo[k] = 1;
                end else begin
                    mw[k] = 0;
                end
            end
            if (c_en) n = (n + 1) % 100;
        end
        @(posedge clk);
        #1;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("wrap_q",    int'(b0.q),          mon_e.q[0]);
            chk("wrap_wrap", int'(b0.wrap),       mon_e.w[0]);
            chk("wrap_tc",   int'(b0.tc),         mon_e.t[0]);
            chk("wrap_ovf",  int'(b0.ovf_sticky), mon_e.o[0]);
            chk("sat_q",     int'(b1.q),          mon_e.q[1]);
            chk("sat_wrap",  int'(b1.wrap),       mon_e.w[1]);
            chk("sat_tc",    int'(b1.tc),         mon_e.t[1]);
            chk("sat_ovf",   int'(b1.ovf_sticky), mon_e.o[1]);
            chk("casc_lo",   int'(bl.q),          mon_e.lo);
            chk("casc_hi",   int'(bh.q),          mon_e.hi);
            chk("casc_tc",   int'(bl.tc),         mon_e.tlo);
        end
    end

    initial begin
        clr  = 1'b0;
        c_en = 1'b0;
        drive(0, 1, 0, 0, 0);
        #1;
        step();
        step();
        clr = 1'b1;

        drive(1, 1, 0, 0, 0);
        repeat (12) step();

        drive(0, 1, 0, 1, 2);
        step();
        drive(1, 0, 0, 0, 0);
        repeat (4) step();

        drive(0, 1, 0, 1, 8);
        step();
        drive(1, 1, 0, 0, 0);
        repeat (4) step();

        drive(1, 1, 1, 1, 5);
        step();
        drive(0, 1, 0, 1, 15);
        step();
        drive(1, 1, 0, 1, 3);
        step();
        drive(0, 1, 0, 0, 0);
        step();

        // Get a wrap pulse pending, then drop clr between edges.
        drive(0, 1, 0, 1, 8);
        step();
        drive(1, 1, 0, 0, 0);
        step();
        step();
        clr = 1'b0;
        step();
        clr = 1'b1;

        drive(0, 1, 0, 0, 0);
        c_en = 1'b1;
        repeat (25) step();
        c_en = 1'b0;
        step();

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 15)));
            c_en = $urandom_range(0, 1) == 1;
            step();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
